command_stream_fifo: RTL
========================

# command_stream_fifo

Sits directly downstream of the `command_dt` 32-bit output PIO, which the HPS writes over Avalon, and a one-bit command strobe PIO. Each transition of the strobe bit captures the current `command_dt` word into an 8-deep first-word-fall-through FIFO. The FIFO presents words to the printer command executor over a valid/ready handshake. It also reports FIFO level, a sticky overflow flag and a count of delivered commands back to HPS-readable PIO inputs.

## Interface
- `DEPTH`, 8: FIFO depth in words; must be a power of two, at least 2.
- `AW`, 3: log2(`DEPTH`).
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `command_dt`  in  32  command word from the output PIO.
- `command_toggle`  in  1  strobe PIO bit. Each level change (0→1 or 1→0) means one new command word.
- `cmd_data`  out  32  head-of-FIFO word.
- `cmd_valid`  out  1  `cmd_data` is valid.
- `cmd_ready`  in  1  the executor accepts the head word.
- `level`  out  AW+1  number of words stored, 0..`DEPTH`.
- `full`  out  1  `level == DEPTH`.
- `overflow`  out  1  sticky flag: a command was dropped.
- `overflow_clr`  in  1  single-cycle clear for `overflow`.
- `accepted_count`  out  16  number of handshakes completed; wraps modulo 2^16.

## Operation
- Toggle detect: `toggle_q` registers `command_toggle` every cycle.
  - `push_req = command_toggle ^ toggle_q`.
  - During reset, `toggle_q` loads `command_toggle`. No spurious push happens at reset release, whatever the level of the strobe bit.
- Data capture: `command_dt` is sampled in the same cycle as `push_req`. Software writes the data PIO before flipping the strobe, so the word is stable.
- `pop = cmd_valid & cmd_ready`.
- `push = push_req & (~full | pop)`. When the FIFO is full, a push is accepted only if a pop happens in the same cycle.
- Storage: `mem[DEPTH]`, with `wr_ptr` and `rd_ptr` each AW bits wide.
  - Both pointers wrap naturally from `DEPTH-1` to 0.
  - `level` is an explicit counter:
    - +1 on push only
    - −1 on pop only
    - unchanged on both or on neither.
- Output: `cmd_data = mem[rd_ptr]`, combinational read. `cmd_valid = (level != 0)`.
- Overflow: when `push_req` is high and the push is not accepted, the word is discarded and `overflow` is set on the next edge.
  - If `overflow_clr` and a new drop occur in the same cycle, set wins.
- `accepted_count` increments by 1 on every pop.
- Pop on empty cannot occur, because `cmd_valid` is low. `cmd_ready` is ignored while `cmd_valid` is low.
- `cmd_data` is undefined while `cmd_valid` is low. The verification bench must not check it then.

## Timing
- Reset values:
  - `level` 0
  - `cmd_valid` 0
  - `full` 0
  - `overflow` 0
  - `accepted_count` 0
  - both pointers 0
  - `cmd_data` undefined (memory is not cleared).
- Push latency: toggle change seen in cycle N → word written at the end of N → `cmd_valid` high and `cmd_data` equal to the word in cycle N+1.
- Pop: the head advances at the end of the cycle in which `pop` is high. The next word, if any, appears in the following cycle.
  - With `cmd_ready` held high, the FIFO sustains one word per cycle.
- Push and pop in the same cycle, at any level including full: `level` is unchanged, and both pointers advance.
- Push and pop in the same cycle at level 1: `cmd_valid` stays high and the new word is shown next cycle.
- Reset asserted mid-operation: all stored words are discarded in that cycle, and the next cycle shows the reset values.
  - A toggle edge that occurs during reset is not captured.
- At most one push per cycle. Software must not toggle faster than once per `clk` cycle; HPS PIO write rate guarantees this.

## Test plan
- Reset with `command_toggle`=1 and release: no push occurs, `level`=0, `cmd_valid`=0.
- Single push: `command_dt`=0x12345678, flip the toggle, `cmd_ready`=0.
  - Next cycle: `cmd_valid`=1, `cmd_data`=0x12345678, `level`=1.
  - Raise `cmd_ready` for one cycle: `level`=0, `accepted_count`=1.
- Fill, then overflow: push 0x00000001..0x00000008 with `cmd_ready`=0.
  - `full`=1.
  - A ninth push of 0x00000009 is dropped and `overflow`=1.
  - Drain: the words read out are 1..8 in order, and `accepted_count`=8.
- Full plus simultaneous push/pop: with the FIFO full, flip the toggle with `cmd_ready`=1.
  - `level` stays 8 and `overflow` stays 0.
  - The new word is read out last, after seven older words.
- Overflow clear versus set in the same cycle: `overflow_clr`=1 in the same cycle as a dropped push leaves `overflow`=1. `overflow_clr` alone clears it to 0.
- Streaming plus mid-run reset: toggle every cycle with `cmd_ready`=1 for 20 cycles.
  - `level` stays ≤1 and all 20 words are delivered in order.
  - Assert `reset` with `level`=3: next cycle `level`=0, `cmd_valid`=0, `accepted_count`=0.

Source files
------------

// File: rtl/command_stream_fifo.sv
// Command stream FIFO: toggle-strobed capture of the HPS command word into a
// first-word-fall-through FIFO with a valid/ready output, level, overflow and delivery count.
module command_stream_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   command_dt,
  input  logic          command_toggle,
  output logic [31:0]   cmd_data,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [AW:0]   level,
  output logic          full,
  output logic          overflow,
  input  logic          overflow_clr,
  output logic [15:0]   accepted_count
);

  logic [31:0]   mem [DEPTH];
  logic          toggle_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_req;
  logic          pop;
  logic          push;
  logic          drop;

  // Handshake decode; a full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    push_req = command_toggle ^ toggle_q;
    pop      = cmd_valid & cmd_ready;
    push     = push_req & (~full | pop);
    drop     = push_req & ~push;
  end

  // Status derived from the registered level counter and storage.
  always_comb begin
    cmd_valid = (level != {(AW+1){1'b0}});
    full      = (level == (AW+1)'(DEPTH));
    cmd_data  = mem[rd_ptr];
  end

  // Storage is not cleared on reset; a push coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= command_dt;
    end else begin
      mem[wr_ptr] <= mem[wr_ptr];
    end
  end

  // Strobe edge tracking, pointers, level, overflow and delivery counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      toggle_q       <= command_toggle;
      wr_ptr         <= {AW{1'b0}};
      rd_ptr         <= {AW{1'b0}};
      level          <= {(AW+1){1'b0}};
      overflow       <= 1'b0;
      accepted_count <= 16'd0;
    end else begin
      toggle_q <= command_toggle;
      if (push) begin
        wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop) begin
        rd_ptr         <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
        accepted_count <= accepted_count + 16'd1;
      end else begin
        rd_ptr         <= rd_ptr;
        accepted_count <= accepted_count;
      end
      case ({push, pop})
        2'b10:   level <= level + {{AW{1'b0}}, 1'b1};
        2'b01:   level <= level - {{AW{1'b0}}, 1'b1};
        default: level <= level;
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end else begin
        overflow <= overflow;
      end
    end
  end

endmodule
